// File: rtl/coletor_senha_if.sv
// Packed-password type and the keypad/verifier bus between the collector,
// the keypad decoder and the password verifier.
package coletor_senha_pkg;
    typedef struct packed {
        logic [19:0][3:0] digits;
    } senhaPac_t;
endpackage

interface coletor_senha_if;
    import coletor_senha_pkg::*;

    logic       key_valid;
    logic [3:0] key_code;
    logic       done;
    logic       senha_ok;
    senhaPac_t  senha_teste;
    logic       valid_out;
    logic [4:0] digit_count;
    logic       busy;
    logic       result_ok;
    logic       result_fail;
    logic       timeout_evt;

    modport master (
        output key_valid, key_code, done, senha_ok,
        input  senha_teste, valid_out, digit_count, busy,
               result_ok, result_fail, timeout_evt
    );

    modport slave (
        input  key_valid, key_code, done, senha_ok,
        output senha_teste, valid_out, digit_count, busy,
               result_ok, result_fail, timeout_evt
    );
endinterface

// File: rtl/coletor_senha.sv
// Keypad password collector: packs digits in entry order, hands the entry to
// the verifier on '#', reports the verdict and discards stale partial entries.
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | buffer empty, waiting for first digit
// COLETA  | collecting digits, inactivity timer running
// ENVIA   | valid_out asserted for one cycle
// AGUARDA | entry frozen, waiting for verifier done
module coletor_senha
    import coletor_senha_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MIN_DIGITS     = 4
) (
    input  logic            clk,
    input  logic            rst,
    coletor_senha_if.slave  bus
);
    localparam int             CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]     MIND = 5'(MIN_DIGITS);

    typedef enum logic [1:0] {IDLE, COLETA, ENVIA, AGUARDA} state_t;

    state_t         state, state_nx;
    senhaPac_t      buf_q, buf_nx;
    logic [4:0]     cnt_q, cnt_nx;
    logic [CW-1:0]  tmr_q, tmr_nx;
    logic           valid_q, valid_nx;
    logic           busy_q, busy_nx;
    logic           ok_q, ok_nx;
    logic           fail_q, fail_nx;
    logic           tout_q, tout_nx;

    logic is_digit, is_clear, is_confirm;

    assign is_digit   = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_clear   = bus.key_valid && (bus.key_code == 4'hA);
    assign is_confirm = bus.key_valid && (bus.key_code == 4'hB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            buf_q   <= '1;
            cnt_q   <= '0;
            tmr_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            buf_q   <= buf_nx;
            cnt_q   <= cnt_nx;
            tmr_q   <= tmr_nx;
            valid_q <= valid_nx;
            busy_q  <= busy_nx;
            ok_q    <= ok_nx;
            fail_q  <= fail_nx;
            tout_q  <= tout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        buf_nx   = buf_q;
        cnt_nx   = cnt_q;
        tmr_nx   = '0;
        valid_nx = 1'b0;
        ok_nx    = 1'b0;
        fail_nx  = 1'b0;
        tout_nx  = 1'b0;

        unique case (state)
            IDLE: begin
                if (is_digit) begin
                    for (int i = 0; i < 20; i++)
                        if (cnt_q == 5'(i)) buf_nx.digits[i] = bus.key_code;
                    cnt_nx   = cnt_q + 5'd1;
                    state_nx = COLETA;
                end
            end
            COLETA: begin
                if (is_digit) begin
                    // A full buffer keeps the most recent 20 digits.
                    if (cnt_q == 5'd20) begin
                        buf_nx.digits = {bus.key_code, buf_q.digits[19:1]};
                    end else begin
                        for (int i = 0; i < 20; i++)
                            if (cnt_q == 5'(i)) buf_nx.digits[i] = bus.key_code;
                        cnt_nx = cnt_q + 5'd1;
                    end
                end else if (is_clear) begin
                    buf_nx   = '1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (is_confirm) begin
                    if (cnt_q >= MIND) begin
                        valid_nx = 1'b1;
                        state_nx = ENVIA;
                    end else begin
                        buf_nx   = '1;
                        cnt_nx   = '0;
                        fail_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end else if (tmr_q == TERM) begin
                    buf_nx   = '1;
                    cnt_nx   = '0;
                    tout_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tmr_nx = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
                end
            end
            ENVIA: begin
                state_nx = AGUARDA;
            end
            AGUARDA: begin
                if (bus.done) begin
                    ok_nx    = bus.senha_ok;
                    fail_nx  = !bus.senha_ok;
                    buf_nx   = '1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == ENVIA) || (state_nx == AGUARDA);
    end

    assign bus.senha_teste = buf_q;
    assign bus.digit_count = cnt_q;
    assign bus.valid_out   = valid_q;
    assign bus.busy        = busy_q;
    assign bus.result_ok   = ok_q;
    assign bus.result_fail = fail_q;
    assign bus.timeout_evt = tout_q;
endmodule

// File: tb/tb_coletor_senha.sv
// Bench for coletor_senha: directed scenarios plus a randomized run checked
// against a queue-based model of the keypad entry rules.
module tb_coletor_senha;
    import coletor_senha_pkg::*;

    localparam int T   = 10;
    localparam int MIN = 4;
    localparam logic [79:0] ALL_F = {80{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   valid_seen = 0;

    coletor_senha_if bus();

    coletor_senha #(.TIMEOUT_CYCLES(T), .MIN_DIGITS(MIN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.valid_out) valid_seen++;

    // Reference model: retained digits, phase of the hand-off, idle cycles.
    int   m_q[$];
    int   m_phase;   // 0 accepting keys, 1 request just issued, 2 awaiting verdict
    int   m_idle;
    logic m_valid, m_ok, m_fail, m_tout;

    function automatic void model_reset();
        m_q.delete();
        m_phase = 0; m_idle = 0;
        m_valid = 0; m_ok = 0; m_fail = 0; m_tout = 0;
    endfunction

    function automatic void model_edge(logic kv, logic [3:0] kc, logic dn, logic ok);
        m_valid = 0; m_ok = 0; m_fail = 0; m_tout = 0;
        if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (dn) begin
                m_ok = ok; m_fail = !ok; m_q.delete(); m_phase = 0;
            end
        end else if (kv && kc <= 9) begin
            m_q.push_back(int'(kc));
            if (m_q.size() > 20) void'(m_q.pop_front());
            m_idle = 0;
        end else if (m_q.size() > 0 && kv && kc == 4'hA) begin
            m_q.delete(); m_idle = 0;
        end else if (m_q.size() > 0 && kv && kc == 4'hB) begin
            m_idle = 0;
            if (m_q.size() >= MIN) begin
                m_phase = 1; m_valid = 1;
            end else begin
                m_q.delete(); m_fail = 1;
            end
        end else if (m_q.size() > 0) begin
            if (m_idle == T - 1) begin
                m_q.delete(); m_tout = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endfunction

    function automatic logic [79:0] model_digits();
        logic [19:0][3:0] d;
        for (int i = 0; i < 20; i++) d[i] = (i < m_q.size()) ? 4'(m_q[i]) : 4'hF;
        return d;
    endfunction

    task automatic cycle(input logic kv, input logic [3:0] kc, input logic dn, input logic ok);
        bus.key_valid = kv; bus.key_code = kc; bus.done = dn; bus.senha_ok = ok;
        @(posedge clk);
        model_edge(kv, kc, dn, ok);
        #1;
        bus.key_valid = 1'b0; bus.done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.senha_teste !== ALL_F) begin failures++;
            $display("FAIL reset_senha got=%h want=%h", bus.senha_teste, ALL_F); end
        checks++;
        if (bus.digit_count !== 5'd0) begin failures++;
            $display("FAIL reset_count got=%0d want=0", bus.digit_count); end
        checks++;
        if ({bus.valid_out, bus.busy, bus.result_ok, bus.result_fail, bus.timeout_evt} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                {bus.valid_out, bus.busy, bus.result_ok, bus.result_fail, bus.timeout_evt});
        end
    endtask

    task automatic test_basic_ok();
        int v0;
        v0 = valid_seen;
        for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 0, 0);
        cycle(1, 4'hB, 0, 0);
        checks++;
        if (bus.senha_teste !== {64'hFFFF_FFFF_FFFF_FFFF, 16'h4321}) begin failures++;
            $display("FAIL basic_digits got=%h want=%h", bus.senha_teste, {64'hFFFF_FFFF_FFFF_FFFF, 16'h4321}); end
        checks++;
        if ({bus.valid_out, bus.busy} !== 2'b11) begin failures++;
            $display("FAIL basic_send got=%b want=11", {bus.valid_out, bus.busy}); end
        cycle(0, 0, 0, 0);
        checks++;
        if ({bus.valid_out, bus.busy} !== 2'b01) begin failures++;
            $display("FAIL basic_wait got=%b want=01", {bus.valid_out, bus.busy}); end
        cycle(0, 0, 1, 1);
        checks++;
        if ({bus.result_ok, bus.result_fail, bus.busy} !== 3'b100) begin failures++;
            $display("FAIL basic_result got=%b want=100", {bus.result_ok, bus.result_fail, bus.busy}); end
        checks++;
        if (bus.senha_teste !== ALL_F || bus.digit_count !== 5'd0) begin failures++;
            $display("FAIL basic_cleared got=%h/%0d want=all F/0", bus.senha_teste, bus.digit_count); end
        cycle(0, 0, 0, 0);
        checks++;
        if (bus.result_ok !== 1'b0 || valid_seen - v0 !== 1) begin failures++;
            $display("FAIL basic_pulses got ok=%b valids=%0d want ok=0 valids=1", bus.result_ok, valid_seen - v0); end
    endtask

    task automatic test_overflow();
        int v0;
        v0 = valid_seen;
        for (int i = 0; i < 22; i++) cycle(1, 4'(i % 10), 0, 0);
        cycle(1, 4'hB, 0, 0);
        checks++;
        if (bus.senha_teste.digits[0] !== 4'd2 || bus.senha_teste.digits[19] !== 4'd1 || bus.digit_count !== 5'd20) begin
            failures++;
            $display("FAIL overflow_digits got d0=%h d19=%h n=%0d want d0=2 d19=1 n=20",
                bus.senha_teste.digits[0], bus.senha_teste.digits[19], bus.digit_count);
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        checks++;
        if ({bus.result_ok, bus.result_fail} !== 2'b01 || valid_seen - v0 !== 1) begin failures++;
            $display("FAIL overflow_result got=%b valids=%0d want=01 valids=1",
                {bus.result_ok, bus.result_fail}, valid_seen - v0); end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_short();
        int v0;
        v0 = valid_seen;
        cycle(1, 4'd5, 0, 0);
        cycle(1, 4'd6, 0, 0);
        cycle(1, 4'hB, 0, 0);
        checks++;
        if ({bus.result_fail, bus.valid_out, bus.busy} !== 3'b100 || bus.digit_count !== 5'd0) begin failures++;
            $display("FAIL short_reject got=%b n=%0d want=100 n=0",
                {bus.result_fail, bus.valid_out, bus.busy}, bus.digit_count); end
        cycle(0, 0, 0, 0);
        checks++;
        if (bus.result_fail !== 1'b0 || valid_seen - v0 !== 0) begin failures++;
            $display("FAIL short_pulse got fail=%b valids=%0d want 0/0", bus.result_fail, valid_seen - v0); end
    endtask

    task automatic test_clear();
        cycle(1, 4'd7, 0, 0);
        cycle(1, 4'd8, 0, 0);
        cycle(1, 4'hA, 0, 0);
        checks++;
        if (bus.senha_teste !== ALL_F || bus.digit_count !== 5'd0 || bus.busy !== 1'b0) begin failures++;
            $display("FAIL clear_buffer got=%h n=%0d busy=%b want all F/0/0",
                bus.senha_teste, bus.digit_count, bus.busy); end
        cycle(1, 4'hB, 0, 0);
        cycle(0, 0, 0, 0);
        checks++;
        if ({bus.valid_out, bus.busy, bus.result_ok, bus.result_fail, bus.timeout_evt} !== 5'b0 || valid_seen != 0 && 0) begin
            failures++;
            $display("FAIL clear_confirm got=%b want=00000",
                {bus.valid_out, bus.busy, bus.result_ok, bus.result_fail, bus.timeout_evt});
        end
    endtask

    task automatic test_timeout();
        logic [T:1] seen;
        cycle(1, 4'd9, 0, 0);
        for (int k = 1; k <= T; k++) begin
            cycle(0, 0, 0, 0);
            seen[k] = bus.timeout_evt;
        end
        checks++;
        if (seen !== {1'b1, {(T-1){1'b0}}}) begin failures++;
            $display("FAIL timeout_edge got=%b want=%b", seen, {1'b1, {(T-1){1'b0}}}); end
        checks++;
        if (bus.senha_teste !== ALL_F || bus.digit_count !== 5'd0) begin failures++;
            $display("FAIL timeout_clear got=%h n=%0d want all F/0", bus.senha_teste, bus.digit_count); end
        // key arriving on the terminal-count edge restarts the timer
        cycle(1, 4'd9, 0, 0);
        for (int k = 1; k < T; k++) cycle(0, 0, 0, 0);
        cycle(1, 4'd3, 0, 0);
        checks++;
        if (bus.timeout_evt !== 1'b0 || bus.digit_count !== 5'd2) begin failures++;
            $display("FAIL timeout_keywins got tout=%b n=%0d want 0/2", bus.timeout_evt, bus.digit_count); end
        for (int k = 1; k <= T; k++) begin
            cycle(0, 0, 0, 0);
            seen[k] = bus.timeout_evt;
        end
        checks++;
        if (seen !== {1'b1, {(T-1){1'b0}}}) begin failures++;
            $display("FAIL timeout_restart got=%b want=%b", seen, {1'b1, {(T-1){1'b0}}}); end
    endtask

    task automatic test_hold_and_reset();
        logic [79:0] snap;
        int bad;
        for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 0, 0);
        cycle(1, 4'hB, 0, 0);
        snap = bus.senha_teste;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            cycle(k % 2 == 0, (k % 4 < 2) ? 4'd1 : 4'd2, 0, 0);
            if (bus.senha_teste !== snap || bus.digit_count !== 5'd4 || bus.busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || snap !== {64'hFFFF_FFFF_FFFF_FFFF, 16'h4321}) begin failures++;
            $display("FAIL hold_stable got bad_cycles=%0d snap=%h want 0/...4321", bad, snap); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.senha_teste !== ALL_F || bus.digit_count !== 5'd0 ||
            {bus.valid_out, bus.busy, bus.result_ok, bus.result_fail, bus.timeout_evt} !== 5'b0) begin
            failures++;
            $display("FAIL hold_reset got=%h n=%0d flags=%b want all F/0/00000", bus.senha_teste, bus.digit_count,
                {bus.valid_out, bus.busy, bus.result_ok, bus.result_fail, bus.timeout_evt});
        end
        bus.done = 1'b1; bus.senha_ok = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
        rst = 1'b0;
        cycle(0, 0, 0, 0);
        checks++;
        if ({bus.result_ok, bus.result_fail, bus.busy} !== 3'b000) begin failures++;
            $display("FAIL hold_noresult got=%b want=000", {bus.result_ok, bus.result_fail, bus.busy}); end
        model_reset();
    endtask

    task automatic test_random();
        int gap, r, bad;
        logic kv, dn, ok;
        logic [3:0] kc;
        logic [91:0] got, exp;
        do_reset();
        gap = 0; bad = 0;
        for (int n = 0; n < 3000; n++) begin
            if (gap > 0) begin
                gap--; kv = 1'b0;
            end else begin
                kv = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 40) == 0) gap = $urandom_range(5, 14);
            end
            r  = $urandom_range(0, 19);
            kc = (r < 14) ? 4'(r % 10) : (r < 16) ? 4'hA : (r < 19) ? 4'hB : 4'($urandom_range(12, 15));
            dn = ($urandom_range(0, 3) == 0);
            ok = 1'($urandom_range(0, 1));
            cycle(kv, kc, dn, ok);
            got = {bus.senha_teste, 2'b0, bus.digit_count, bus.valid_out, bus.busy,
                   bus.result_ok, bus.result_fail, bus.timeout_evt};
            exp = {model_digits(), 2'b0, 5'(m_q.size()), m_valid, (m_phase != 0),
                   m_ok, m_fail, m_tout};
            checks++;
            if (got !== exp) begin
                failures++;
                if (bad < 10) $display("FAIL random_cycle%0d got=%h want=%h", n, got, exp);
                bad++;
            end
        end
    endtask

    initial begin
        bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.done = 1'b0; bus.senha_ok = 1'b0;
        test_reset();
        test_basic_ok();
        test_overflow();
        test_short();
        test_clear();
        test_timeout();
        test_hold_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coletor_senha.md
# coletor_senha

Keypad-entry collector for the door lock, directly upstream of the password verifier. Accepts one key code per pulse and packs digits in entry order into a 20-digit `senhaPac_t`, with unused digits set to 4'hF. On the confirm key it issues a single-cycle `valid_out` to the verifier and holds the packed password stable until the verifier's `done`. It then reports the result and clears the buffer. An inactivity timeout discards partial entries.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles in COLETA before the partial entry is discarded (≥2).
- `MIN_DIGITS`, default 4: minimum digit count for an entry to be forwarded (1..20).
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `key_valid` input, 1 bit: one-cycle pulse, `key_code` is valid.
- `key_code` input, 4 bits: 0–9 digit, 4'hA '*' (clear), 4'hB '#' (confirm); 4'hC–4'hF are ignored.
- `done` input, 1 bit: verifier finished (one-cycle).
- `senha_ok` input, 1 bit: verifier result, qualified by `done`.
- `senha_teste` output, `senhaPac_t`: packed entry; `digits[i]` is the i-th retained digit.
- `valid_out` output, 1 bit: one-cycle request to the verifier.
- `digit_count` output, 5 bits: digits currently buffered (0..20).
- `busy` output, 1 bit: high in ENVIA/AGUARDA.
- `result_ok` output, 1 bit: one-cycle pulse, verifier accepted the entry.
- `result_fail` output, 1 bit: one-cycle pulse, verifier rejected the entry, or the entry was too short.
- `timeout_evt` output, 1 bit: one-cycle pulse, partial entry discarded by timeout.

## Operation
- States:
  - IDLE: empty buffer.
  - COLETA: collecting digits.
  - ENVIA: `valid_out` high.
  - AGUARDA: waiting for `done`.
- Digit key, IDLE or COLETA:
  - If `digit_count` < 20: `digits[digit_count]` <= key, count+1.
  - If count = 20: shift `digits[0..18]` <= `digits[1..19]`, `digits[19]` <= key, count stays 20 (last 20 retained).
  - IDLE→COLETA.
- '*' in COLETA: all digits <= 4'hF, count <= 0, →IDLE. '*' in IDLE: no effect.
- '#' in COLETA:
  - If count ≥ `MIN_DIGITS`: →ENVIA.
  - Otherwise: clear buffer, pulse `result_fail`, →IDLE.
- '#' in IDLE: ignored.
- ENVIA: `valid_out` = 1 for exactly one cycle, →AGUARDA.
- AGUARDA: on `done` = 1, pulse `result_ok` = `senha_ok` and `result_fail` = !`senha_ok`, clear buffer, →IDLE.
- All keys are ignored in ENVIA/AGUARDA. `senha_teste` must not change from entry to ENVIA until leaving AGUARDA.
- Timeout counter:
  - Cleared on every accepted key and in every state other than COLETA.
  - Increments in COLETA.
  - When it reaches `TIMEOUT_CYCLES`-1 with no key that cycle: clear buffer, pulse `timeout_evt`, →IDLE.
- `done` outside AGUARDA is ignored.

## Timing
- Reset values:
  - state IDLE.
  - all `senha_teste.digits` = 4'hF.
  - `digit_count` = 0.
  - `valid_out`, `busy`, `result_ok`, `result_fail`, `timeout_evt` = 0.
  - timeout counter = 0.
- Reset mid-operation (including AGUARDA) aborts immediately with no result pulse.
- All outputs are registered. A key sampled at edge N is visible in `senha_teste`/`digit_count` after edge N.
- '#' sampled at edge N: `valid_out` = 1 in cycle N+1, `busy` = 1 from N+1.
- `done` sampled at edge M: result pulse and cleared buffer appear in cycle M+1, `busy` = 0 from M+1. Keys are accepted again from edge M+1.
- Key and timeout terminal count in the same cycle: the key wins and the counter restarts.
- Short-entry '#': `result_fail` appears in the cycle after '#', and no `valid_out` is issued.
- Minimum cycles from '#' to next accepted key: 3, given `done` on the first AGUARDA cycle.
- The counter is sized `$clog2(TIMEOUT_CYCLES)` bits and saturates; it never wraps.

## Test plan
- Keys 1,2,3,4,'#' then `done`=1 with `senha_ok`=1 two cycles later:
  - after '#', `digits[0..3]`=1,2,3,4 and `digits[4..19]`=F.
  - one `valid_out` pulse.
  - `result_ok` pulse.
  - buffer all F, count 0.
- 22 digit keys 0,1,…,9,0,1,… then '#':
  - `digits[0]`=2, `digits[19]`=1, count 20.
  - `valid_out` pulses once.
- Keys 5,6,'#' with `MIN_DIGITS`=4:
  - `result_fail` pulse the next cycle, no `valid_out`, count 0.
- Keys 7,8 then '*':
  - buffer all F, state IDLE.
  - a further '#' produces no output.
- `TIMEOUT_CYCLES`=10, key 9, then idle:
  - `timeout_evt` exactly 10 cycles after the key's edge, buffer cleared.
  - repeat with a key on cycle 9: no timeout.
- After '#' with `done` held low 15 cycles while keys 1,2 are pulsed:
  - `senha_teste` unchanged, keys ignored.
  - assert `rst` mid-AGUARDA: all outputs at reset values, no result pulse.
